// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared types and defaults for the result controller
package result_pkg;

    localparam int DEF_NUM_SLOTS = 10;
    localparam int DEF_DATA_W    = 16;
    localparam int IDX_W         = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        CLEAR   = 2'd2
    } state_e;

endpackage

// File: rtl/result_controller_rr_arbiter2.sv
// rtl/result_controller_rr_arbiter2.sv - two-input round-robin arbiter with enable
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q == 0 favours requester 0 (A), 1 favours requester 1 (B)
    logic ptr_q;
    logic ptr_d;

    // pick a winner and move the pointer away from whoever won
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/result_controller.sv
// rtl/result_controller.sv - result register file sequencer/arbiter; optional error flag under RESULT_CTRL_ERR_EN
module result_controller
    import result_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    input  logic              start_drain,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              rf_w_enable,
    output logic [IDX_W-1:0]  rf_in_sel,
    output logic [DATA_W-1:0] rf_in_data,
    output logic              rf_clear,
    output logic [IDX_W-1:0]  rf_out_sel,
    input  logic [DATA_W-1:0] rf_out_data,
    output logic [IDX_W-1:0]  count,
    output logic              full,
    output logic              busy,
    output logic              err
);

    localparam logic [IDX_W-1:0] SLOTS_L = IDX_W'(NUM_SLOTS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] last_idx;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             drain_ok;

    assign full     = (count_q == SLOTS_L);
    assign busy     = (state_q != COLLECT);
    assign count    = count_q;
    assign last_idx = count_q - 1'b1;
    assign arb_en   = (state_q == COLLECT) && !full;
    assign gnt_a    = gnt[0];
    assign gnt_b    = gnt[1];
    // a drain is accepted only if it will find at least one entry, counting a same-cycle write
    assign drain_ok = (state_q == COLLECT) && start_drain && (count_d != '0);

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req_b, req_a}),
        .gnt (gnt)
    );

    // next-state, counters and register-file/stream outputs
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        rf_w_enable = 1'b0;
        rf_in_sel   = '0;
        rf_in_data  = '0;
        rf_clear    = 1'b0;
        rf_out_sel  = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (state_q)
            COLLECT: begin
                if (gnt != 2'b00) begin
                    rf_w_enable = 1'b1;
                    rf_in_sel   = count_q;
                    rf_in_data  = gnt[0] ? data_a : data_b;
                    count_d     = count_q + 1'b1;
                end
                if (start_drain && (count_d != '0)) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                end
            end
            DRAIN: begin
                out_valid  = 1'b1;
                rf_out_sel = rd_ptr_q;
                out_data   = rf_out_data;
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == last_idx) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                rf_clear = 1'b1;
                count_d  = '0;
                rd_ptr_d = '0;
                state_d  = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // state, count and read pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef RESULT_CTRL_ERR_EN
    logic err_q, err_d;

    // sticky error: request against a full file, or a drain request that finds nothing
    always_comb begin
        err_d = err_q;
        if (state_q == CLEAR) begin
            err_d = 1'b0;
        end else if (state_q == COLLECT) begin
            if ((full && (req_a || req_b)) || (start_drain && !drain_ok)) begin
                err_d = 1'b1;
            end
        end
    end

    // error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_result_controller.sv
// tb/tb_result_controller.sv - scoreboard bench for result_controller
module tb_result_controller;

    localparam bit ERR_ON =
`ifdef RESULT_CTRL_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] data;
        logic        ga;
        logic        gb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        gnt_a, gnt_b;
    logic        start_drain = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        rf_w_enable;
    logic [3:0]  rf_in_sel;
    logic [15:0] rf_in_data;
    logic        rf_clear;
    logic [3:0]  rf_out_sel;
    logic [15:0] rf_out_data;
    logic [3:0]  count;
    logic        full, busy, err;

    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;
    wr_t         wq[$];
    logic [15:0] sq[$];
    logic [15:0] rf [0:15];

    always #5 clk = ~clk;

    result_controller dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .start_drain(start_drain),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rf_w_enable(rf_w_enable), .rf_in_sel(rf_in_sel), .rf_in_data(rf_in_data),
        .rf_clear(rf_clear), .rf_out_sel(rf_out_sel), .rf_out_data(rf_out_data),
        .count(count), .full(full), .busy(busy), .err(err)
    );

    // register file model
    always @(posedge clk or posedge rst) begin
        if (rst || rf_clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (rf_w_enable) begin
            rf[rf_in_sel] <= rf_in_data;
        end
    end
    assign rf_out_data = rf[rf_out_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pop expectations whenever the DUT writes or hands off a beat
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_clear) clr_cnt++;
            if ((gnt_a || gnt_b) && !rf_w_enable) chk("grant_without_write", 1, 0);
            if (rf_w_enable) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {rf_in_sel, rf_in_data}, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write", {rf_in_sel, rf_in_data, gnt_a, gnt_b}, {e.sel, e.data, e.ga, e.gb});
                end
            end
            if (out_valid && out_ready) begin
                if (sq.size() == 0) begin
                    chk("unexpected_beat", out_data, 0);
                end else begin
                    logic [15:0] d;
                    d = sq.pop_front();
                    chk("beat", out_data, d);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_a = 0; req_b = 0; start_drain = 0; out_ready = 0;
        rst = 1;
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cyc();
            k++;
        end
        chk("drain_done", busy, 0);
    endtask

    initial begin
        int c0;
        // reset state
        cyc(); cyc();
        chk("rst_count", count, 0);
        chk("rst_flags", {full, busy, err, out_valid}, 0);
        chk("rst_rf", {rf_w_enable, rf_clear, rf_out_sel, gnt_a, gnt_b}, 0);
        rst = 0;

        // A alone posts two results, third write coincides with start_drain
        req_a = 1; data_a = 16'h1111; wq.push_back('{4'd0, 16'h1111, 1'b1, 1'b0}); cyc();
        data_a = 16'h2222; wq.push_back('{4'd1, 16'h2222, 1'b1, 1'b0}); cyc();
        chk("t1_count2", count, 2);
        data_a = 16'h3333; start_drain = 1; out_ready = 1;
        wq.push_back('{4'd2, 16'h3333, 1'b1, 1'b0});
        sq.push_back(16'h1111); sq.push_back(16'h2222); sq.push_back(16'h3333);
        cyc();
        req_a = 0; start_drain = 0;
        chk("t1_drain_count", count, 3);
        chk("t1_busy", busy, 1);
        wait_idle(20);
        chk("t1_cleared", count, 0);
        chk("t1_err", err, 0);
        out_ready = 0;

        // both requesting from reset alternate A,B,A,B then fill with A
        apply_reset();
        req_a = 1; req_b = 1;
        for (int i = 0; i < 4; i++) begin
            data_a = 16'h0A00 + 16'(i);
            data_b = 16'h0B00 + 16'(i);
            if (i % 2 == 0) wq.push_back('{4'(i), 16'h0A00 + 16'(i), 1'b1, 1'b0});
            else            wq.push_back('{4'(i), 16'h0B00 + 16'(i), 1'b0, 1'b1});
            cyc();
        end
        req_b = 0;
        chk("t2_count4", count, 4);
        for (int i = 4; i < 10; i++) begin
            data_a = 16'h0C00 + 16'(i);
            wq.push_back('{4'(i), 16'h0C00 + 16'(i), 1'b1, 1'b0});
            cyc();
        end
        chk("t3_full", full, 1);
        chk("t3_blocked", {gnt_a, gnt_b, rf_w_enable}, 0);
        cyc();
        chk("t3_count10", count, 10);
        chk("t3_err", err, ERR_ON);
        // drain while A keeps requesting; its pending result lands in slot 0 afterwards
        sq.push_back(16'h0A00); sq.push_back(16'h0B01); sq.push_back(16'h0A02); sq.push_back(16'h0B03);
        for (int i = 4; i < 10; i++) sq.push_back(16'h0C00 + 16'(i));
        data_a = 16'h0D00;
        wq.push_back('{4'd0, 16'h0D00, 1'b1, 1'b0});
        out_ready = 1; start_drain = 1;
        cyc();
        start_drain = 0;
        wait_idle(30);
        chk("t3_err_cleared", err, 0);
        cyc();
        req_a = 0; out_ready = 0;
        chk("t3_post_count", count, 1);

        // three results drained with backpressure 1,0,1,1
        apply_reset();
        req_a = 1;
        data_a = 16'hAAAA; wq.push_back('{4'd0, 16'hAAAA, 1'b1, 1'b0}); cyc();
        data_a = 16'hBBBB; wq.push_back('{4'd1, 16'hBBBB, 1'b1, 1'b0}); cyc();
        data_a = 16'hCCCC; wq.push_back('{4'd2, 16'hCCCC, 1'b1, 1'b0}); cyc();
        req_a = 0;
        sq.push_back(16'hAAAA); sq.push_back(16'hBBBB); sq.push_back(16'hCCCC);
        c0 = clr_cnt;
        start_drain = 1; cyc();
        start_drain = 0; out_ready = 1; #1;
        chk("t4_d0", {out_valid, out_data}, {1'b1, 16'hAAAA});
        cyc(); out_ready = 0; #1;
        chk("t4_d1", {out_valid, out_data}, {1'b1, 16'hBBBB});
        cyc(); out_ready = 1; #1;
        chk("t4_d1_held", {out_valid, out_data}, {1'b1, 16'hBBBB});
        cyc(); #1;
        chk("t4_d2", {out_valid, out_data}, {1'b1, 16'hCCCC});
        cyc(); out_ready = 0; #1;
        chk("t4_clear", {rf_clear, busy, out_valid}, 3'b110);
        cyc();
        chk("t4_idle", {busy, rf_clear}, 0);
        chk("t4_count0", count, 0);
        chk("t4_one_clear", clr_cnt - c0, 1);

        // start_drain on an empty file is ignored
        start_drain = 1; cyc();
        start_drain = 0; #1;
        chk("t5_no_drain", {busy, out_valid}, 0);
        chk("t5_err", err, ERR_ON);

        // reset in the middle of a drain
        apply_reset();
        req_a = 1;
        data_a = 16'h5555; wq.push_back('{4'd0, 16'h5555, 1'b1, 1'b0}); cyc();
        data_a = 16'h6666; wq.push_back('{4'd1, 16'h6666, 1'b1, 1'b0}); cyc();
        req_a = 0;
        sq.push_back(16'h5555);
        start_drain = 1; cyc();
        start_drain = 0; out_ready = 1; cyc();
        out_ready = 0; rst = 1; #1;
        chk("t6_rst_out", {out_valid, busy}, 0);
        chk("t6_rst_count", count, 0);
        cyc();
        rst = 0;
        req_a = 1; data_a = 16'h7777; wq.push_back('{4'd0, 16'h7777, 1'b1, 1'b0}); cyc();
        req_a = 0;
        chk("t6_count1", count, 1);

        cyc(); cyc();
        chk("wq_empty", wq.size(), 0);
        chk("sq_empty", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
